// File: rtl/unique_codec_pkg.sv
// rtl/unique_codec_pkg.sv - shared widths and token type for the unique-value encoder/decoder pair
package unique_codec_pkg;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int IDX_W  = $clog2(DEPTH);

   typedef struct packed {
      logic              hit;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic              last;
   } token_t;

endpackage

// File: rtl/unique_encoder_if.sv
// rtl/unique_encoder_if.sv - symbol-in / token-out handshake bundle of the unique-value encoder
interface unique_encoder_if;
   import unique_codec_pkg::*;

   logic                  s_valid_in;
   logic                  s_ready_out;
   logic [DATA_W-1:0]     s_data_in;
   logic                  s_last_in;
   logic                  m_valid_out;
   logic                  m_ready_in;
   logic                  m_hit_out;
   logic [IDX_W-1:0]      m_idx_out;
   logic [DATA_W-1:0]     m_data_out;
   logic                  m_last_out;

   // encoder side
   modport slave (
      input  s_valid_in, s_data_in, s_last_in, m_ready_in,
      output s_ready_out, m_valid_out, m_hit_out, m_idx_out, m_data_out, m_last_out
   );

   // producer/consumer side
   modport master (
      output s_valid_in, s_data_in, s_last_in, m_ready_in,
      input  s_ready_out, m_valid_out, m_hit_out, m_idx_out, m_data_out, m_last_out
   );

endinterface

// File: rtl/unique_history.sv
// rtl/unique_history.sv - move-to-front history with lowest-index parallel match
module unique_history
   import unique_codec_pkg::*;
(
   input  logic              clk_in,
   input  logic              reset_n_in,
   input  logic              accept_in,
   input  logic              clear_in,
   input  logic              last_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              hit_out,
   output logic [IDX_W-1:0]  idx_out
);

   logic [DATA_W-1:0] hist_q [DEPTH];
   logic [DATA_W-1:0] hist_d [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  valid_d;
   logic              match_found;
   logic [IDX_W-1:0]  match_idx;

   // parallel compare; scanning downward lets the lowest matching index win
   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid_q[i] && (hist_q[i] == data_in)) begin
            match_found = 1'b1;
            match_idx   = IDX_W'(i);
         end
      end
   end

   // a flush in the same cycle forces a literal, since the decoder flushes first too
   assign hit_out = match_found & ~clear_in;
   assign idx_out = hit_out ? match_idx : '0;

   // next history: frame end / flush wipe, otherwise move-to-front on accept
   always_comb begin
      hist_d  = hist_q;
      valid_d = valid_q;
      if (accept_in && last_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist_d[i] = '0;
         end
         valid_d = '0;
      end else if (clear_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist_d[i] = '0;
         end
         valid_d = '0;
         if (accept_in) begin
            hist_d[0]  = data_in;
            valid_d[0] = 1'b1;
         end
      end else if (accept_in) begin
         for (int i = 1; i < DEPTH; i++) begin
            if (!match_found || (IDX_W'(i) <= match_idx)) begin
               hist_d[i]  = hist_q[i-1];
               valid_d[i] = valid_q[i-1];
            end
         end
         hist_d[0]  = data_in;
         valid_d[0] = 1'b1;
      end
   end

   // history registers
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            hist_q[i] <= hist_d[i];
         end
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/unique_encoder.sv
// rtl/unique_encoder.sv - move-to-front token encoder top; UNIQUE_ENC_STATS_EN adds hit/literal counters
module unique_encoder
   import unique_codec_pkg::*;
(
   input  logic               clk_in,
   input  logic               reset_n_in,
   input  logic               clear_in,
   unique_encoder_if.slave    bus
`ifdef UNIQUE_ENC_STATS_EN
   ,
   output logic [31:0]        hit_cnt_out,
   output logic [31:0]        lit_cnt_out
`endif
);

   logic             accept;
   logic             hist_hit;
   logic [IDX_W-1:0] hist_idx;
   logic             m_valid_q;
   logic             m_valid_d;
   token_t           tok_q;
   token_t           tok_d;

   assign bus.s_ready_out = ~m_valid_q | bus.m_ready_in;
   assign accept          = bus.s_valid_in & bus.s_ready_out;

   unique_history u_history (
      .clk_in     (clk_in),
      .reset_n_in (reset_n_in),
      .accept_in  (accept),
      .clear_in   (clear_in),
      .last_in    (bus.s_last_in),
      .data_in    (bus.s_data_in),
      .hit_out    (hist_hit),
      .idx_out    (hist_idx)
   );

   // output stage: load on accept, drop when taken with nothing new behind it
   always_comb begin
      m_valid_d = m_valid_q;
      tok_d     = tok_q;
      if (accept) begin
         m_valid_d  = 1'b1;
         tok_d.hit  = hist_hit;
         tok_d.idx  = hist_idx;
         tok_d.data = bus.s_data_in;
         tok_d.last = bus.s_last_in;
      end else if (bus.m_ready_in) begin
         m_valid_d = 1'b0;
      end
   end

   // output registers
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         m_valid_q <= 1'b0;
         tok_q     <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         tok_q     <= tok_d;
      end
   end

   assign bus.m_valid_out = m_valid_q;
   assign bus.m_hit_out   = tok_q.hit;
   assign bus.m_idx_out   = tok_q.idx;
   assign bus.m_data_out  = tok_q.data;
   assign bus.m_last_out  = tok_q.last;

`ifdef UNIQUE_ENC_STATS_EN
   logic        take;
   logic [31:0] hit_cnt_q;
   logic [31:0] hit_cnt_d;
   logic [31:0] lit_cnt_q;
   logic [31:0] lit_cnt_d;

   assign take = m_valid_q & bus.m_ready_in;

   // saturating per-type token counters, counted when the token leaves
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      lit_cnt_d = lit_cnt_q;
      if (take && tok_q.hit && (hit_cnt_q != '1)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (take && !tok_q.hit && (lit_cnt_q != '1)) begin
         lit_cnt_d = lit_cnt_q + 32'd1;
      end
   end

   // counter registers, untouched by clear_in
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         hit_cnt_q <= '0;
         lit_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
         lit_cnt_q <= lit_cnt_d;
      end
   end

   assign hit_cnt_out = hit_cnt_q;
   assign lit_cnt_out = lit_cnt_q;
`endif

endmodule
